kernel_axi_rd_arbiter: RTL and testbench
========================================

Name: kernel_axi_rd_arbiter

Overview:
- Parametrised N-kernel read-channel arbiter between KERNEL_NUM action kernels and the single host-memory AXI master read port (m_axi_snap_ar*/r*).
- Successor to the fixed 8-kernel framework's shared read path.
- Adds generic kernel count, per-kernel outstanding-burst limiting, ID-based read-data routing and error flagging.
- Sits inside the action framework, between the kernel array and the host AXI master.

Parameters:
- KERNEL_NUM, 8, number of kernel ports (1..2**KID_WIDTH).
- KID_WIDTH, 3, kernel-index bits in master ID (>= clog2(KERNEL_NUM)).
- C_M_AXI_HOST_MEM_ID_WIDTH, 5, master ID width.
- LID_WIDTH, 2, kernel-local ID bits; must equal ID_WIDTH-KID_WIDTH.
- C_M_AXI_HOST_MEM_ADDR_WIDTH, 64, address width.
- C_M_AXI_HOST_MEM_DATA_WIDTH, 512, data width.
- MAX_OUTSTANDING, 16, max in-flight bursts per kernel (counter width clog2(MAX_OUTSTANDING+1)).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- k_arvalid  in  KERNEL_NUM  per-kernel AR valid
- k_arready  out  KERNEL_NUM  per-kernel AR ready (one-hot grant)
- k_araddr  in  KERNEL_NUM*ADDR_WIDTH  flattened addresses, kernel 0 in LSBs
- k_arlen  in  KERNEL_NUM*8  flattened burst lengths
- k_arid  in  KERNEL_NUM*LID_WIDTH  flattened local IDs
- k_rvalid  out  KERNEL_NUM  per-kernel R valid
- k_rready  in  KERNEL_NUM  per-kernel R ready
- k_rdata  out  DATA_WIDTH  broadcast R data
- k_rid  out  LID_WIDTH  local ID of current beat
- k_rresp  out  2  broadcast response
- k_rlast  out  1  broadcast last
- m_axi_snap_arid/araddr/arlen/arsize/arburst/arcache/arprot/arqos/arregion/aruser  out  std widths  master AR fields
- m_axi_snap_arvalid  out  1; m_axi_snap_arready  in  1
- m_axi_snap_rid/rdata/rresp/rlast/rvalid  in  std widths; m_axi_snap_rready  out  1
- o_idle  out  1  no AR pending and all outstanding counters zero
- o_err_rid  out  1  sticky: R beat with illegal kernel index or to a kernel with zero outstanding
- i_perf_sel  in  KID_WIDTH  perf counter select
- i_perf_clr  in  1  perf counter clear
- o_perf_bursts  out  32  granted-burst count of selected kernel
- o_perf_beats  out  32  received-beat count of selected kernel

Behaviour:
- Reset (rst_n low at clk edge): all outputs 0 (k_arready, m_axi_snap_arvalid, o_err_rid, perf outputs included); outstanding counters 0; RR pointer = KERNEL_NUM-1 so kernel 0 has first priority. In-flight bursts are abandoned; stray R beats after reset set o_err_rid.
- AR slot: one output register. Slot free when !arvalid or (arvalid && arready).
- Eligibility: kernel k eligible = k_arvalid[k] && cnt[k] < MAX_OUTSTANDING.
- Grant:
  - When the slot is free and any kernel is eligible, grant the first eligible kernel searching from ptr+1 with wrap. Same cycle: k_arready[g]=1 (combinational), slot loaded, ptr<=g.
  - m_axi_snap_arvalid rises the next cycle and holds, fields stable, until arready.
  - Back-to-back: one grant per cycle while m_axi_snap_arready=1.
- Master AR fields: arid={g[KID_WIDTH-1:0], local id}; arsize=clog2(DATA_WIDTH/8) (3'b110 at 512); arburst=2'b01; arcache=4'b0011; arprot/arqos/arregion/aruser=0.
- Counters: cnt[k] +1 on grant; -1 on k_rvalid[k]&&k_rready[k]&&k_rlast; both in the same cycle leaves it unchanged. A decrement at 0 is not applied and sets o_err_rid.
- R path (combinational, 0 latency):
  - Routing: kidx = m_axi_snap_rid[ID_WIDTH-1 -: KID_WIDTH]; k_rvalid[k] = m_axi_snap_rvalid && kidx==k; m_axi_snap_rready = k_rready[kidx]; k_rid = low LID_WIDTH bits of m_axi_snap_rid.
  - Illegal index (kidx >= KERNEL_NUM): m_axi_snap_rready=1, beat dropped, o_err_rid set.
- o_err_rid clears only on reset.
- o_idle is registered: 1 when the slot is empty, all cnt=0 and no k_arvalid asserted.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- Defined:
  - Per-kernel 32-bit burst counter (+1 per grant) and beat counter (+1 per routed R handshake).
  - Both saturate at 32'hFFFFFFFF.
  - i_perf_clr zeroes all counters synchronously; it takes priority over increments.
  - o_perf_bursts/o_perf_beats are the registered value of the kernel selected by i_perf_sel, 1-cycle latency.
- Undefined: no counter logic; perf outputs tied 0; i_perf_sel and i_perf_clr ignored.

Test Plan:
- All 8 kernels assert arvalid continuously, m_axi_snap_arready=1 -> grants 0,1,...,7,0 on consecutive cycles; arid upper bits match the granted kernel.
- Kernel 2 issues 16 bursts with no R data, MAX_OUTSTANDING=16 -> 17th request is blocked while other kernels are still granted; one rlast beat to kernel 2 -> its next request is granted.
- m_axi_snap_arready held 0 for 5 cycles -> arvalid, araddr and arid stay stable; no extra k_arready pulses.
- R beats with rid=5'b01110 and k_rready[3]=0 -> k_rvalid[3]=1 and m_axi_snap_rready=0; k_rid=2'b10.
- KERNEL_NUM=6 and an R beat with kidx=7 -> beat consumed, o_err_rid=1 until reset; rst_n pulsed low mid-burst -> all outputs 0 the next cycle and counters cleared.
- ARB_PERF_CNT_EN: 3 bursts of arlen=3 to kernel 1, i_perf_sel=1 -> o_perf_bursts=3, o_perf_beats=12; i_perf_clr -> both 0.

Source files
------------

// File: rtl/kernel_axi_rd_arbiter.sv
// kernel_axi_rd_arbiter: round-robin arbiter sharing one host-memory AXI read
// port between KERNEL_NUM kernels. Requests pass through a single registered AR
// slot. Read data is steered back by the kernel index held in the upper
// ARID bits. Each kernel has an outstanding-burst limit, and a sticky flag
// records unroutable read beats.
// Optional build macro ARB_PERF_CNT_EN adds per-kernel burst/beat counters.
//
// Handshake semantics (all channels): a transfer happens on a rising clk edge
// where valid && ready. valid never waits on ready. Once the master AR valid
// is raised, its payload holds stable until the transfer completes.
module kernel_axi_rd_arbiter #(
    parameter int KERNEL_NUM                    = 8,
    parameter int KID_WIDTH                     = 3,
    parameter int C_M_AXI_HOST_MEM_ID_WIDTH     = 5,
    parameter int LID_WIDTH                     = 2,
    parameter int C_M_AXI_HOST_MEM_ADDR_WIDTH   = 64,
    parameter int C_M_AXI_HOST_MEM_DATA_WIDTH   = 512,
    parameter int MAX_OUTSTANDING               = 16,
    parameter int C_M_AXI_HOST_MEM_ARUSER_WIDTH = 1
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic [KERNEL_NUM-1:0]                             k_arvalid,
    output logic [KERNEL_NUM-1:0]                             k_arready,
    input  logic [KERNEL_NUM*C_M_AXI_HOST_MEM_ADDR_WIDTH-1:0] k_araddr,
    input  logic [KERNEL_NUM*8-1:0]                           k_arlen,
    input  logic [KERNEL_NUM*LID_WIDTH-1:0]                   k_arid,
    output logic [KERNEL_NUM-1:0]                             k_rvalid,
    input  logic [KERNEL_NUM-1:0]                             k_rready,
    output logic [C_M_AXI_HOST_MEM_DATA_WIDTH-1:0]            k_rdata,
    output logic [LID_WIDTH-1:0]                              k_rid,
    output logic [1:0]                                        k_rresp,
    output logic                                              k_rlast,
    output logic [C_M_AXI_HOST_MEM_ID_WIDTH-1:0]              m_axi_snap_arid,
    output logic [C_M_AXI_HOST_MEM_ADDR_WIDTH-1:0]            m_axi_snap_araddr,
    output logic [7:0]                                        m_axi_snap_arlen,
    output logic [2:0]                                        m_axi_snap_arsize,
    output logic [1:0]                                        m_axi_snap_arburst,
    output logic [3:0]                                        m_axi_snap_arcache,
    output logic [2:0]                                        m_axi_snap_arprot,
    output logic [3:0]                                        m_axi_snap_arqos,
    output logic [3:0]                                        m_axi_snap_arregion,
    output logic [C_M_AXI_HOST_MEM_ARUSER_WIDTH-1:0]          m_axi_snap_aruser,
    output logic                                              m_axi_snap_arvalid,
    input  logic                                              m_axi_snap_arready,
    input  logic [C_M_AXI_HOST_MEM_ID_WIDTH-1:0]              m_axi_snap_rid,
    input  logic [C_M_AXI_HOST_MEM_DATA_WIDTH-1:0]            m_axi_snap_rdata,
    input  logic [1:0]                                        m_axi_snap_rresp,
    input  logic                                              m_axi_snap_rlast,
    input  logic                                              m_axi_snap_rvalid,
    output logic                                              m_axi_snap_rready,
    output logic                                              o_idle,
    output logic                                              o_err_rid,
    input  logic [KID_WIDTH-1:0]                              i_perf_sel,
    input  logic                                              i_perf_clr,
    output logic [31:0]                                       o_perf_bursts,
    output logic [31:0]                                       o_perf_beats
);

    localparam int IDW    = C_M_AXI_HOST_MEM_ID_WIDTH;
    localparam int AW     = C_M_AXI_HOST_MEM_ADDR_WIDTH;
    localparam int DW     = C_M_AXI_HOST_MEM_DATA_WIDTH;
    // Internal per-kernel vectors are padded to the full index space so that
    // any KID_WIDTH-bit index selects a real bit (unused slots read as 0).
    localparam int KSLOTS = 1 << KID_WIDTH;
    localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int SIZE   = $clog2(DW / 8);

    // AR output slot and arbitration state
    logic                 ar_valid;
    logic [IDW-1:0]       ar_id;
    logic [AW-1:0]        ar_addr;
    logic [7:0]           ar_len;
    logic [KID_WIDTH-1:0] ptr;
    logic [CNT_W-1:0]     cnt [KERNEL_NUM];

    logic [KSLOTS-1:0]    elig_pad;
    logic [KSLOTS-1:0]    grant_pad;
    logic [KSLOTS-1:0]    rready_pad;
    logic [KID_WIDTH:0]   idx;
    logic [KID_WIDTH-1:0] grant_idx;
    logic                 grant_found;
    logic                 grant_vld;
    logic                 slot_free;
    logic [AW-1:0]        sel_addr;
    logic [7:0]           sel_len;
    logic [LID_WIDTH-1:0] sel_lid;
    logic [KID_WIDTH-1:0] kidx;
    logic                 kidx_bad;
    logic [KERNEL_NUM-1:0] r_hs;
    logic                 zero_hit;
    logic                 cnt_all_zero;

    // Eligibility: request pending and below the in-flight burst limit
    always_comb begin
        elig_pad = '0;
        for (int k = 0; k < KERNEL_NUM; k++) begin
            elig_pad[k] = k_arvalid[k] && (cnt[k] < CNT_W'(MAX_OUTSTANDING));
        end
    end

    // Round-robin search starting just after the last granted kernel
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = ptr;
        idx         = '0;
        for (int i = 1; i <= KERNEL_NUM; i++) begin
            idx = {1'b0, ptr} + (KID_WIDTH+1)'(i);
            if (idx >= (KID_WIDTH+1)'(KERNEL_NUM)) begin
                idx = idx - (KID_WIDTH+1)'(KERNEL_NUM);
            end
            if (!grant_found && elig_pad[idx[KID_WIDTH-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = idx[KID_WIDTH-1:0];
            end
        end
    end

    assign slot_free = !ar_valid || m_axi_snap_arready;
    // Grants are suppressed while reset is asserted so k_arready reads 0.
    assign grant_vld = rst_n && slot_free && grant_found;

    // One-hot grant pulse back to the winning kernel
    always_comb begin
        grant_pad            = '0;
        grant_pad[grant_idx] = grant_vld;
    end
    assign k_arready = grant_pad[KERNEL_NUM-1:0];

    // Select the winning kernel's request fields
    always_comb begin
        sel_addr = '0;
        sel_len  = '0;
        sel_lid  = '0;
        for (int k = 0; k < KERNEL_NUM; k++) begin
            if (grant_idx == KID_WIDTH'(k)) begin
                sel_addr = k_araddr[k*AW +: AW];
                sel_len  = k_arlen[k*8 +: 8];
                sel_lid  = k_arid[k*LID_WIDTH +: LID_WIDTH];
            end
        end
    end

    // AR slot: load on grant, empty when the master accepts without a refill
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ar_valid <= 1'b0;
            ar_id    <= '0;
            ar_addr  <= '0;
            ar_len   <= '0;
            ptr      <= KID_WIDTH'(KERNEL_NUM - 1);
        end else if (grant_vld) begin
            ar_valid <= 1'b1;
            ar_id    <= {grant_idx, sel_lid};
            ar_addr  <= sel_addr;
            ar_len   <= sel_len;
            ptr      <= grant_idx;
        end else if (m_axi_snap_arready) begin
            ar_valid <= 1'b0;
        end
    end

    assign m_axi_snap_arvalid  = ar_valid;
    assign m_axi_snap_arid     = ar_id;
    assign m_axi_snap_araddr   = ar_addr;
    assign m_axi_snap_arlen    = ar_len;
    assign m_axi_snap_arsize   = 3'(SIZE);
    assign m_axi_snap_arburst  = 2'b01;
    assign m_axi_snap_arcache  = 4'b0011;
    assign m_axi_snap_arprot   = '0;
    assign m_axi_snap_arqos    = '0;
    assign m_axi_snap_arregion = '0;
    assign m_axi_snap_aruser   = '0;

    // R path: steer each beat to the kernel named by the upper ID bits
    assign kidx     = m_axi_snap_rid[IDW-1 -: KID_WIDTH];
    assign kidx_bad = ({1'b0, kidx} >= (KID_WIDTH+1)'(KERNEL_NUM));

    always_comb begin
        rready_pad                   = '0;
        rready_pad[KERNEL_NUM-1:0]   = k_rready;
        m_axi_snap_rready            = kidx_bad || rready_pad[kidx];
        for (int k = 0; k < KERNEL_NUM; k++) begin
            k_rvalid[k] = m_axi_snap_rvalid && (kidx == KID_WIDTH'(k));
            r_hs[k]     = k_rvalid[k] && k_rready[k];
        end
    end

    assign k_rid   = m_axi_snap_rid[LID_WIDTH-1:0];
    assign k_rdata = m_axi_snap_rdata;
    assign k_rresp = m_axi_snap_rresp;
    assign k_rlast = m_axi_snap_rlast;

    // Detect beats routed to a kernel with nothing outstanding; summarise idle
    always_comb begin
        zero_hit     = 1'b0;
        cnt_all_zero = 1'b1;
        for (int k = 0; k < KERNEL_NUM; k++) begin
            if (r_hs[k] && (cnt[k] == '0)) zero_hit = 1'b1;
            if (cnt[k] != '0) cnt_all_zero = 1'b0;
        end
    end

    // Outstanding-burst counters, sticky routing error and registered idle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < KERNEL_NUM; k++) cnt[k] <= '0;
            o_err_rid <= 1'b0;
            o_idle    <= 1'b0;
        end else begin
            for (int k = 0; k < KERNEL_NUM; k++) begin
                case ({k_arready[k], r_hs[k] && m_axi_snap_rlast})
                    2'b10:   cnt[k] <= cnt[k] + CNT_W'(1);
                    2'b01:   if (cnt[k] != '0) cnt[k] <= cnt[k] - CNT_W'(1);
                    default: cnt[k] <= cnt[k];
                endcase
            end
            if (zero_hit || (m_axi_snap_rvalid && kidx_bad)) o_err_rid <= 1'b1;
            o_idle <= !ar_valid && cnt_all_zero && !(|k_arvalid);
        end
    end

`ifdef ARB_PERF_CNT_EN
    logic [31:0]       perf_bursts [KSLOTS];
    logic [31:0]       perf_beats  [KSLOTS];
    logic [KSLOTS-1:0] beat_pad;

    always_comb begin
        beat_pad                 = '0;
        beat_pad[KERNEL_NUM-1:0] = r_hs;
    end

    // Saturating per-kernel counters; clear wins over increment
    always_ff @(posedge clk) begin
        if (!rst_n || i_perf_clr) begin
            for (int k = 0; k < KSLOTS; k++) begin
                perf_bursts[k] <= '0;
                perf_beats[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < KSLOTS; k++) begin
                if (grant_pad[k] && (perf_bursts[k] != 32'hFFFF_FFFF))
                    perf_bursts[k] <= perf_bursts[k] + 32'd1;
                if (beat_pad[k] && (perf_beats[k] != 32'hFFFF_FFFF))
                    perf_beats[k] <= perf_beats[k] + 32'd1;
            end
        end
    end

    // Registered view of the selected kernel's counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_perf_bursts <= '0;
            o_perf_beats  <= '0;
        end else begin
            o_perf_bursts <= perf_bursts[i_perf_sel];
            o_perf_beats  <= perf_beats[i_perf_sel];
        end
    end
`else
    logic unused_perf;
    assign unused_perf   = ^{i_perf_sel, i_perf_clr};
    assign o_perf_bursts = '0;
    assign o_perf_beats  = '0;
`endif

endmodule

// File: tb/tb_kernel_axi_rd_arbiter.sv
// Directed bench for kernel_axi_rd_arbiter: an 8-kernel instance for grant
// order, burst limiting, AR stall, R routing, reset and perf counters, and a
// 6-kernel instance for wrap order and illegal kernel indices.
module tb_kernel_axi_rd_arbiter;

    localparam int K   = 8;
    localparam int K6  = 6;
    localparam int IDW = 5;
    localparam int AW  = 64;
    localparam int DW  = 512;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- 8-kernel instance signals ----------------
    logic [K-1:0]      k_arvalid, k_arready, k_rvalid, k_rready;
    logic [K*AW-1:0]   k_araddr;
    logic [K*8-1:0]    k_arlen;
    logic [K*2-1:0]    k_arid;
    logic [DW-1:0]     k_rdata;
    logic [1:0]        k_rid, k_rresp;
    logic              k_rlast;
    logic [IDW-1:0]    m_arid;
    logic [AW-1:0]     m_araddr;
    logic [7:0]        m_arlen;
    logic [2:0]        m_arsize, m_arprot;
    logic [1:0]        m_arburst;
    logic [3:0]        m_arcache, m_arqos, m_arregion;
    logic [0:0]        m_aruser;
    logic              m_arvalid, m_arready;
    logic [IDW-1:0]    m_rid;
    logic [DW-1:0]     m_rdata;
    logic [1:0]        m_rresp;
    logic              m_rlast, m_rvalid, m_rready;
    logic              o_idle, o_err_rid;
    logic [2:0]        i_perf_sel;
    logic              i_perf_clr;
    logic [31:0]       o_perf_bursts, o_perf_beats;

    // ---------------- 6-kernel instance signals ----------------
    logic [K6-1:0]     k6_arvalid, k6_arready, k6_rvalid, k6_rready;
    logic [K6*AW-1:0]  k6_araddr;
    logic [K6*8-1:0]   k6_arlen;
    logic [K6*2-1:0]   k6_arid;
    logic [DW-1:0]     k6_rdata;
    logic [1:0]        k6_rid, k6_rresp;
    logic              k6_rlast;
    logic [IDW-1:0]    m6_arid;
    logic [AW-1:0]     m6_araddr;
    logic [7:0]        m6_arlen;
    logic [2:0]        m6_arsize, m6_arprot;
    logic [1:0]        m6_arburst;
    logic [3:0]        m6_arcache, m6_arqos, m6_arregion;
    logic [0:0]        m6_aruser;
    logic              m6_arvalid, m6_arready;
    logic [IDW-1:0]    m6_rid;
    logic [DW-1:0]     m6_rdata;
    logic [1:0]        m6_rresp;
    logic              m6_rlast, m6_rvalid, m6_rready;
    logic              o6_idle, o6_err_rid;
    logic [31:0]       o6_perf_bursts, o6_perf_beats;

    kernel_axi_rd_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .k_arvalid(k_arvalid), .k_arready(k_arready), .k_araddr(k_araddr),
        .k_arlen(k_arlen), .k_arid(k_arid),
        .k_rvalid(k_rvalid), .k_rready(k_rready), .k_rdata(k_rdata),
        .k_rid(k_rid), .k_rresp(k_rresp), .k_rlast(k_rlast),
        .m_axi_snap_arid(m_arid), .m_axi_snap_araddr(m_araddr),
        .m_axi_snap_arlen(m_arlen), .m_axi_snap_arsize(m_arsize),
        .m_axi_snap_arburst(m_arburst), .m_axi_snap_arcache(m_arcache),
        .m_axi_snap_arprot(m_arprot), .m_axi_snap_arqos(m_arqos),
        .m_axi_snap_arregion(m_arregion), .m_axi_snap_aruser(m_aruser),
        .m_axi_snap_arvalid(m_arvalid), .m_axi_snap_arready(m_arready),
        .m_axi_snap_rid(m_rid), .m_axi_snap_rdata(m_rdata),
        .m_axi_snap_rresp(m_rresp), .m_axi_snap_rlast(m_rlast),
        .m_axi_snap_rvalid(m_rvalid), .m_axi_snap_rready(m_rready),
        .o_idle(o_idle), .o_err_rid(o_err_rid),
        .i_perf_sel(i_perf_sel), .i_perf_clr(i_perf_clr),
        .o_perf_bursts(o_perf_bursts), .o_perf_beats(o_perf_beats)
    );

    kernel_axi_rd_arbiter #(.KERNEL_NUM(K6)) dut6 (
        .clk(clk), .rst_n(rst_n),
        .k_arvalid(k6_arvalid), .k_arready(k6_arready), .k_araddr(k6_araddr),
        .k_arlen(k6_arlen), .k_arid(k6_arid),
        .k_rvalid(k6_rvalid), .k_rready(k6_rready), .k_rdata(k6_rdata),
        .k_rid(k6_rid), .k_rresp(k6_rresp), .k_rlast(k6_rlast),
        .m_axi_snap_arid(m6_arid), .m_axi_snap_araddr(m6_araddr),
        .m_axi_snap_arlen(m6_arlen), .m_axi_snap_arsize(m6_arsize),
        .m_axi_snap_arburst(m6_arburst), .m_axi_snap_arcache(m6_arcache),
        .m_axi_snap_arprot(m6_arprot), .m_axi_snap_arqos(m6_arqos),
        .m_axi_snap_arregion(m6_arregion), .m_axi_snap_aruser(m6_aruser),
        .m_axi_snap_arvalid(m6_arvalid), .m_axi_snap_arready(m6_arready),
        .m_axi_snap_rid(m6_rid), .m_axi_snap_rdata(m6_rdata),
        .m_axi_snap_rresp(m6_rresp), .m_axi_snap_rlast(m6_rlast),
        .m_axi_snap_rvalid(m6_rvalid), .m_axi_snap_rready(m6_rready),
        .o_idle(o6_idle), .o_err_rid(o6_err_rid),
        .i_perf_sel(3'd0), .i_perf_clr(1'b0),
        .o_perf_bursts(o6_perf_bursts), .o_perf_beats(o6_perf_beats)
    );

    // ---------------- scoreboard ----------------
    logic [IDW+AW-1:0] exp_q[$];
    logic [IDW+AW-1:0] popped;
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [AW-1:0] a,
                           input logic [7:0] len, input logic [1:0] lid);
        k_araddr[k*AW +: AW] = a;
        k_arlen[k*8 +: 8]    = len;
        k_arid[k*2 +: 2]     = lid;
    endtask

    task automatic idle_inputs();
        k_arvalid = '0; k_araddr = '0; k_arlen = '0; k_arid = '0; k_rready = '0;
        m_arready = 1'b0; m_rid = '0; m_rdata = '0; m_rresp = '0;
        m_rlast = 1'b0; m_rvalid = 1'b0; i_perf_sel = '0; i_perf_clr = 1'b0;
        k6_arvalid = '0; k6_araddr = '0; k6_arlen = '0; k6_arid = '0; k6_rready = '0;
        m6_arready = 1'b0; m6_rid = '0; m6_rdata = '0; m6_rresp = '0;
        m6_rlast = 1'b0; m6_rvalid = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        check({tag, "_arready"}, k_arready, 0);
        check({tag, "_arvalid"}, m_arvalid, 0);
        check({tag, "_err"},     o_err_rid, 0);
        check({tag, "_idle"},    o_idle, 0);
        check({tag, "_perf"},    {o_perf_bursts, o_perf_beats}, 0);
        check({tag, "_err6"},    o6_err_rid, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [2:0]  gk;
        logic [31:0] r;

        do_reset("rst0");

        // All kernels request continuously: 0..7 then 0 again
        for (int k = 0; k < K; k++) set_req(k, 64'h1000 * (k + 1), 8'(k), 2'(k));
        k_arvalid = '1;
        m_arready = 1'b1;
        #1;
        for (int c = 0; c < 9; c++) begin
            gk = 3'(c % K);
            check("rr_grant", k_arready, 128'(1) << gk);
            exp_q.push_back({gk, 2'(gk), 64'h1000 * (64'(gk) + 1)});
            tick();
            check("rr_arvalid", m_arvalid, 1);
            popped = exp_q.pop_front();
            check("rr_ar", {m_arid, m_araddr}, popped);
        end
        k_arvalid = '0;
        check("ar_const", {m_arsize, m_arburst, m_arcache, m_arprot, m_arqos, m_arregion, m_aruser},
              {3'b110, 2'b01, 4'b0011, 3'b0, 4'b0, 4'b0, 1'b0});
        tick();
        check("rr_drain", m_arvalid, 0);

        // Outstanding limit on kernel 2
        do_reset("rst1");
        set_req(2, 64'hA000, 8'd0, 2'd0);
        set_req(5, 64'hB000, 8'd0, 2'd1);
        k_arvalid = 8'h04;
        m_arready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            check("lim_grant", k_arready, 8'h04);
            tick();
        end
        #1;
        check("lim_block", k_arready, 0);
        k_arvalid = 8'h24;
        #1;
        check("lim_other", k_arready, 8'h20);
        tick();
        k_arvalid = 8'h04;
        #1;
        check("lim_still", k_arready, 0);
        m_rid = 5'b01000; m_rlast = 1'b1; m_rvalid = 1'b1; k_rready = 8'h04;
        #1;
        check("lim_rroute", {k_rvalid, m_rready}, {8'h04, 1'b1});
        tick();
        m_rvalid = 1'b0; m_rlast = 1'b0; k_rready = '0;
        #1;
        check("lim_regrant", k_arready, 8'h04);
        check("lim_err", o_err_rid, 0);

        // AR stall: payload stable while the master is not ready
        do_reset("rst2");
        set_req(4, 64'hDEAD_0040, 8'd7, 2'd1);
        set_req(6, 64'hBEEF_0060, 8'd2, 2'd3);
        k_arvalid = 8'h50;
        #1;
        check("stall_grant", k_arready, 8'h10);
        exp_q.push_back({3'd4, 2'd1, 64'hDEAD_0040});
        tick();
        k_arvalid = 8'h40;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_hold", {m_arvalid, m_arlen, m_arid, m_araddr}, {1'b1, 8'd7, exp_q[0]});
            check("stall_noready", k_arready, 0);
            tick();
        end
        m_arready = 1'b1;
        #1;
        check("stall_release", k_arready, 8'h40);
        exp_q.push_back({3'd6, 2'd3, 64'hBEEF_0060});
        tick();
        popped = exp_q.pop_front();
        k_arvalid = '0;
        check("stall_next", {m_arvalid, m_arid, m_araddr}, {1'b1, exp_q[0]});
        tick();
        popped = exp_q.pop_front();
        check("stall_empty", {m_arvalid, 32'(exp_q.size())}, 0);

        // R routing with the destination kernel not ready
        r = $urandom;
        m_rid = 5'b01110; m_rdata = {16{r}}; m_rresp = 2'b10; m_rvalid = 1'b1;
        k_rready = 8'hF7;
        #1;
        check("r_route", {k_rvalid, m_rready, k_rid, k_rresp}, {8'h08, 1'b0, 2'b10, 2'b10});
        check("r_data", k_rdata[127:0], {4{r}});
        k_rready = 8'h08;
        #1;
        check("r_ready", m_rready, 1);
        m_rvalid = 1'b0; k_rready = '0;
        #1;
        check("r_quiet", k_rvalid, 0);

        // Six kernels: wrap from 5 back to 0
        k6_arvalid = 6'h3F;
        m6_arready = 1'b1;
        #1;
        for (int c = 0; c < 7; c++) begin
            check("w6_grant", k6_arready, 128'(1) << (c % K6));
            tick();
        end
        k6_arvalid = '0;
        // Illegal kernel index 7 on the six-kernel instance
        m6_rid = 5'b11101; m6_rvalid = 1'b1;
        #1;
        check("bad_consume", {m6_rready, k6_rvalid}, {1'b1, 6'h0});
        tick();
        m6_rvalid = 1'b0;
        check("bad_err", o6_err_rid, 1);
        tick();
        tick();
        check("bad_sticky", o6_err_rid, 1);

        // Reset mid-burst, then a stray last beat
        set_req(1, 64'h7000, 8'd3, 2'd2);
        k_arvalid = 8'h02;
        m_arready = 1'b1;
        #1;
        check("mid_grant", k_arready, 8'h02);
        tick();
        k_arvalid = '0;
        m_rid = 5'b00110; m_rvalid = 1'b1; k_rready = 8'h02;
        tick();
        m_rvalid = 1'b0;
        check("mid_noerr", o_err_rid, 0);
        rst_n = 1'b0;
        tick();
        check("mid_rst", {k_arready, m_arvalid, o_err_rid, o_idle, o6_err_rid}, 0);
        rst_n = 1'b1;
        m_rlast = 1'b1; m_rvalid = 1'b1;
        tick();
        m_rvalid = 1'b0; m_rlast = 1'b0; k_rready = '0;
        check("stray_err", o_err_rid, 1);
        tick();
        check("stray_sticky", o_err_rid, 1);

        // Three 4-beat bursts on kernel 1, then counters and idle
        do_reset("rst3");
        i_perf_sel = 3'd1;
        m_arready  = 1'b1;
        for (int b = 0; b < 3; b++) begin
            set_req(1, 64'h9000 + 64'(b) * 64'h100, 8'd3, 2'(b));
            k_arvalid = 8'h02;
            #1;
            check("perf_grant", k_arready, 8'h02);
            tick();
            k_arvalid = '0;
            for (int j = 0; j < 4; j++) begin
                m_rid = {3'd1, 2'(b)}; m_rvalid = 1'b1; m_rlast = (j == 3); k_rready = 8'h02;
                tick();
            end
            m_rvalid = 1'b0; m_rlast = 1'b0; k_rready = '0;
        end
        tick();
        tick();
        check("perf_err", o_err_rid, 0);
        check("perf_idle", o_idle, 1);
`ifdef ARB_PERF_CNT_EN
        check("perf_counts", {o_perf_bursts, o_perf_beats}, {32'd3, 32'd12});
        i_perf_clr = 1'b1;
        tick();
        i_perf_clr = 1'b0;
        tick();
        tick();
        check("perf_clear", {o_perf_bursts, o_perf_beats}, 0);
`else
        check("perf_off", {o_perf_bursts, o_perf_beats}, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
